// File: rtl/tsb_arb_pkg.sv
// rtl/tsb_arb_pkg.sv - shared types and helpers for the tri-state bus arbiter
//
// Purpose : FSM state encoding and a constant-evaluable clog2 used for
//           sizing index, pointer and counter widths.
// Ports   : none (package).
package tsb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } arb_state_e;

   // Smallest r with 2**r >= value; 0 for value <= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/tsb_rr_pick.sv
// rtl/tsb_rr_pick.sv - combinational round-robin winner search
//
// Purpose : finds the first set request bit searching upward from last+1
//           with wrap-around (rotate, priority-encode, unrotate).
// Ports   : req_i    [N_REQ-1:0]  request vector
//           last_i   [IW-1:0]     index of the previous owner
//           winner_o [IW-1:0]     selected requester, valid when valid_o=1
//           valid_o               at least one request present
module tsb_rr_pick
   import tsb_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   localparam int IW   = clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    last_i,
   output logic [IW-1:0]    winner_o,
   output logic             valid_o
);

   localparam logic [IW:0] N_W = (IW + 1)'(N_REQ);

   logic [IW:0]         start;
   logic [IW:0]         sum;
   logic [2*N_REQ-1:0]  dbl;
   logic [N_REQ-1:0]    rot;
   logic [IW-1:0]       off;

   always_comb begin
      // Wrap explicitly so non-power-of-two N_REQ also works.
      start = (last_i == IW'(N_REQ - 1)) ? '0 : {1'b0, last_i} + 1'b1;
      dbl   = {req_i, req_i} >> start;
      rot   = dbl[N_REQ-1:0];
      valid_o = |rot;
      off = '0;
      // Descending scan so the lowest rotated offset wins.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = IW'(i);
         end
      end
      sum = {1'b0, off} + start;
      if (sum >= N_W) begin
         sum = sum - N_W;
      end
      winner_o = sum[IW-1:0];
   end

endmodule

// File: rtl/tsb_bus_arbiter.sv
// rtl/tsb_bus_arbiter.sv - round-robin owner arbiter for a shared tri-state line
//
// Purpose : grants the line to one requester at a time, drives its buffer
//           gate, inserts an all-gates-low turnaround between owners and
//           forces release after MAX_HOLD cycles (0 = unlimited).
// Ports   : clk_i                 clock, rising edge
//           rst_n_i               asynchronous active-low reset
//           req_i     [N_REQ-1:0] level requests
//           gate_o    [N_REQ-1:0] registered buffer enables, one-hot or zero
//           owner_o   [IW-1:0]    current owner, valid when busy_o=1
//           busy_o                high while any gate is high
//           preempt_o             one-cycle pulse on hold-limit release
module tsb_bus_arbiter
   import tsb_arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int TURN_CYC = 1,
   parameter int MAX_HOLD = 16,
   localparam int IW      = clog2(N_REQ)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [N_REQ-1:0] req_i,
   output logic [N_REQ-1:0] gate_o,
   output logic [IW-1:0]    owner_o,
   output logic             busy_o,
   output logic             preempt_o
);

   localparam int HW = (MAX_HOLD == 0) ? 1 : clog2(MAX_HOLD + 1);
   localparam int TW = clog2(TURN_CYC + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

   arb_state_e       state_q, state_d;
   logic [N_REQ-1:0] gate_q, gate_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    last_q, last_d;
   logic             busy_q, busy_d;
   logic             preempt_q, preempt_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [TW-1:0]    turn_q, turn_d;

   logic [IW-1:0]    win;
   logic             win_valid;
   logic             drop;
   logic             expire;

   tsb_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_i    (req_i),
      .last_i   (last_q),
      .winner_o (win),
      .valid_o  (win_valid)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         gate_q    <= '0;
         owner_q   <= '0;
         last_q    <= IW'(N_REQ - 1);
         busy_q    <= 1'b0;
         preempt_q <= 1'b0;
         hold_q    <= '0;
         turn_q    <= '0;
      end else begin
         state_q   <= state_d;
         gate_q    <= gate_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         preempt_q <= preempt_d;
         hold_q    <= hold_d;
         turn_q    <= turn_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gate_d    = gate_q;
      owner_d   = owner_q;
      last_d    = last_q;
      busy_d    = busy_q;
      preempt_d = 1'b0;
      hold_d    = hold_q;
      turn_d    = turn_q;
      drop      = !req_i[owner_q];
      expire    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               gate_d  = {{(N_REQ - 1){1'b0}}, 1'b1} << win;
               owner_d = win;
               busy_d  = 1'b1;
               hold_d  = '0;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (drop || expire) begin
               gate_d    = '0;
               busy_d    = 1'b0;
               last_d    = owner_q;
               turn_d    = TURN_LAST;
               state_d   = ST_TURN;
               // A drop coinciding with expiry is treated as voluntary.
               preempt_d = expire && !drop;
            end else if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_TURN: begin
            if (turn_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               turn_d = turn_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (MAX_HOLD == 0) begin
         hold_d = '0;
      end
   end

   assign gate_o    = gate_q;
   assign owner_o   = owner_q;
   assign busy_o    = busy_q;
   assign preempt_o = preempt_q;

   a_gate_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_n_i)
      $onehot0(gate_q));
   a_busy_match : assert property (@(posedge clk_i) disable iff (!rst_n_i)
      busy_q == (|gate_q));
   a_no_overlap : assert property (@(posedge clk_i) disable iff (!rst_n_i)
      ((gate_q != '0) && ($past(gate_q) != '0)) |-> (gate_q == $past(gate_q)));

endmodule

// File: tb/tb_tsb_bus_arbiter.sv
// tb/tb_tsb_bus_arbiter.sv - scoreboard bench for the tri-state bus arbiter
module tb_tsb_bus_arbiter;

   typedef struct {
      int owner;
      int len;
      int gap;
      int pre;
   } ep_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0110;
   logic [3:0] req3 = 4'b0000;
   logic [3:0] gate_o, gate3;
   logic [1:0] owner_o, owner3;
   logic       busy_o, busy3;
   logic       preempt_o, preempt3;

   int   n_checks = 0;
   int   n_errors = 0;
   ep_t  sb[$];

   always #5 clk = ~clk;

   tsb_bus_arbiter #(.N_REQ(4), .TURN_CYC(1), .MAX_HOLD(16)) u_dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .req_i     (req),
      .gate_o    (gate_o),
      .owner_o   (owner_o),
      .busy_o    (busy_o),
      .preempt_o (preempt_o)
   );

   tsb_bus_arbiter #(.N_REQ(4), .TURN_CYC(3), .MAX_HOLD(16)) u_dut3 (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .req_i     (req3),
      .gate_o    (gate3),
      .owner_o   (owner3),
      .busy_o    (busy3),
      .preempt_o (preempt3)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic ep_t ep(input int owner, input int len, input int gap, input int pre);
      ep_t e;
      e.owner = owner;
      e.len   = len;
      e.gap   = gap;
      e.pre   = pre;
      return e;
   endfunction

   // Grant-episode monitor: measures each ownership interval and the gap
   // before it, then checks against the next expected episode (-1 = don't care).
   int  cyc = 0, rise_cyc = 0, fall_cyc = 0, cur_gap = -1, cur_owner = 0;
   bit  prev_nz = 1'b0, gap_known = 1'b0, pre_next = 1'b0;
   ep_t e_mon;

   always @(negedge clk) begin
      cyc++;
      if (pre_next) begin
         chk("preempt_width", preempt_o, 0);
         pre_next = 1'b0;
      end
      if (gate_o != 4'b0 && !prev_nz) begin
         rise_cyc  = cyc;
         cur_gap   = gap_known ? cyc - fall_cyc : -1;
         cur_owner = int'(owner_o);
         chk("gate_vs_owner", gate_o, 1 << owner_o);
         chk("busy_on", busy_o, 1);
      end
      if (gate_o == 4'b0 && prev_nz) begin
         fall_cyc  = cyc;
         gap_known = 1'b1;
         pre_next  = 1'b1;
         chk("busy_off", busy_o, 0);
         if (sb.size() == 0) begin
            chk("sb_underflow", sb.size(), 1);
         end else begin
            e_mon = sb.pop_front();
            chk("owner", cur_owner, e_mon.owner);
            if (e_mon.len >= 0) chk("hold_len", cyc - rise_cyc, e_mon.len);
            if (e_mon.gap >= 0) chk("gap", cur_gap, e_mon.gap);
            chk("preempt", preempt_o, e_mon.pre);
         end
      end
      if (!rst_n) gap_known = 1'b0;
      prev_nz = (gate_o != 4'b0);
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      int  grants;
      int  cnt;
      bit  pend;

      // Reset state and first grant with requesters 1 and 2 pending.
      repeat (2) @(negedge clk);
      chk("rst_gate", gate_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_owner", owner_o, 0);
      chk("rst_preempt", preempt_o, 0);
      sb.push_back(ep(1, 1, -1, 0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_gate", gate_o, 4'b0010);
      chk("first_owner", owner_o, 1);
      req = 4'b0000;
      repeat (6) @(negedge clk);

      // Round-robin: all request, each owner drops after 3 cycles.
      sb.push_back(ep(0, 3, -1, 0));
      sb.push_back(ep(1, 3, 2, 0));
      sb.push_back(ep(2, 3, 2, 0));
      sb.push_back(ep(3, 3, 2, 0));
      sb.push_back(ep(0, 3, 2, 0));
      do_reset();
      req = 4'b1111;
      grants = 0;
      cnt = 0;
      pend = 1'b0;
      for (int c = 0; c < 300 && grants < 5; c++) begin
         @(negedge clk);
         if (pend) begin
            req = 4'b1111;
            pend = 1'b0;
         end
         if (gate_o != 4'b0) begin
            cnt++;
            if (cnt == 3) begin
               req = req & ~gate_o;
               pend = 1'b1;
               cnt = 0;
               grants++;
            end
         end
      end
      chk("rr_grants", grants, 5);
      @(negedge clk);
      req = 4'b0000;
      repeat (6) @(negedge clk);

      // Preemption of a sole requester, then re-grant after the gap.
      sb.push_back(ep(0, 16, -1, 1));
      sb.push_back(ep(0, 16, 2, 1));
      sb.push_back(ep(0, 4, 2, 0));
      do_reset();
      req = 4'b0001;
      repeat (40) @(negedge clk);
      req = 4'b0000;
      repeat (6) @(negedge clk);

      // Drop on the same edge the hold limit is reached: voluntary release.
      sb.push_back(ep(0, 16, -1, 0));
      do_reset();
      req = 4'b0001;
      repeat (16) @(negedge clk);
      req = 4'b0000;
      repeat (6) @(negedge clk);

      // Asynchronous reset mid-grant, then requester 0 regains priority.
      sb.push_back(ep(2, -1, -1, 0));
      sb.push_back(ep(0, 2, -1, 0));
      do_reset();
      req = 4'b0100;
      @(negedge clk);
      chk("ar_gate_pre", gate_o, 4'b0100);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_gate", gate_o, 0);
      chk("ar_busy", busy_o, 0);
      chk("ar_owner", owner_o, 0);
      req = 4'b0101;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      req = 4'b0000;
      repeat (6) @(negedge clk);

      // Turnaround of 3 cycles on the second instance.
      do_reset();
      req3 = 4'b1100;
      @(negedge clk);
      chk("t3_gate_first", gate3, 4'b0100);
      chk("t3_owner_first", owner3, 2);
      req3 = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t3_gap_gate", gate3, 0);
         chk("t3_gap_busy", busy3, 0);
      end
      chk("t3_preempt", preempt3, 0);
      @(negedge clk);
      chk("t3_gate_next", gate3, 4'b1000);
      chk("t3_owner_next", owner3, 3);
      req3 = 4'b0000;
      repeat (6) @(negedge clk);

      chk("sb_left", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
